// File: rtl/tape_mem_arbiter.sv
// Round-robin arbiter that lets the head/step unit (port 0) and the tape loader (port 1)
// share the single-port tape RAM, with exactly one access in flight at a time.
module tape_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_SPACE = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_SPACE-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_SPACE-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_d,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    win_q, win_d;
  logic [ADDR_SPACE-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    sel;

  // Pointer only breaks ties; a lone requester always wins.
  assign sel = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    rdata_d   = rdata_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[sel] = 1'b1;
          win_d          = sel;
          ptr_d          = ~sel;
          addr_d         = sel ? req_addr[2*ADDR_SPACE-1:ADDR_SPACE] : req_addr[ADDR_SPACE-1:0];
          wdata_d        = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          we_d           = req_we[sel];
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        state_d = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        rdata_d = ram_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[win_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_d     = wdata_q;
  assign ram_we    = we_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: doc/tape_mem_arbiter.md
Name: tape_mem_arbiter

Overview:
- Shares the single-port tape RAM between two requesters.
  - Port 0: the head/step unit.
  - Port 1: the tape loader/host.
- Uses round-robin arbitration with one transaction in flight.
- Drives the RAM address, write-data and write-enable pins, captures RAM read data and returns it on the winning port.
- Sits directly between the Turing-machine control logic and the ram instance.

Parameters:
- DATA_WIDTH, 32, width of the RAM word and of the request/response data.
- ADDR_SPACE, 14, RAM address width.

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  bit i set: port i is requesting.
- req_we  in  2  bit i: 1 = write, 0 = read.
- req_addr  in  2*ADDR_SPACE  port i address in slice [i*ADDR_SPACE +: ADDR_SPACE].
- req_wdata  in  2*DATA_WIDTH  port i write data, sliced the same way.
- req_ready  out  2  one-hot, 1-cycle accept pulse.
- rsp_valid  out  2  one-hot, 1-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid while the port's rsp_valid bit is high.
- ram_addr  out  ADDR_SPACE  to RAM addr.
- ram_d  out  DATA_WIDTH  to RAM d.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_WIDTH  from RAM out; valid 1 cycle after the address is presented.

Behaviour:
- Reset (async, while rst_n=0) forces:
  - state=IDLE, ram_we=0, ram_addr=0, ram_d=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - Priority pointer = port 0.
- States are IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid bit is set, select the winner.
    - Only one port valid: that port wins.
    - Both valid: the pointer port wins.
  - req_ready[winner]=1 in this same cycle (combinational from state and req_valid).
  - At the clock edge:
    - Register winner addr/wdata/we into ram_addr/ram_d/ram_we.
    - Store the winner id.
    - Set pointer = the other port.
    - Go to ISSUE.
  - No valid request: stay in IDLE, ram_we=0.
- ISSUE:
  - ram_we equals the stored we. The RAM writes at the end of this cycle.
  - At the edge, ram_we goes to 0. Go to RESP if this is a write, CAPTURE if it is a read.
- CAPTURE:
  - ram_q holds the data for ram_addr.
  - Latch ram_q into rsp_rdata at the edge, then go to RESP.
- RESP:
  - rsp_valid[winner]=1 for exactly this cycle.
  - rsp_rdata is held from CAPTURE; on a write it is unchanged.
  - Next state is IDLE.
- Latency from the accept cycle N:
  - Write: RAM write edge ends N+1; rsp_valid at N+2.
  - Read: rsp_valid with data at N+3.
- Throughput and holding:
  - At most one access in flight.
  - req_valid/req_addr/req_we/req_wdata are sampled only in the accept cycle. Requesters may change them afterwards.
  - A non-accepted requester must hold req_valid and its fields until req_ready.
- ram_addr and ram_d hold their last values outside ISSUE. ram_we is 1 only in ISSUE.
- Simultaneous requests: strict alternation. Neither port waits more than one other transaction.
- Both ports are not granted in the same cycle. req_ready is never two-hot.
- Same-address write followed by read, from either port: the read returns the newly written data.
- Reset mid-operation:
  - ram_we drops immediately (async), so no partial write is committed after the reset edge.
  - The pending response is dropped. The requester re-issues.
- Address wrap-around is the RAM's concern. The arbiter passes addresses through unmodified.

Test Plan:
- Reset: with rst_n=0, check all outputs are 0. Release reset, assert req_valid=2'b01, we=1, addr=5, wdata=32'h3 → req_ready=01 in that cycle, ram_we=1 for exactly 1 cycle with ram_addr=5 and ram_d=3, rsp_valid=01 two cycles after accept.
- Read after write: port 0 reads addr 5 → rsp_valid=01 three cycles after accept, rsp_rdata=32'h3. Then port 1 writes addr 5 = 32'hFFFF and port 0 reads addr 5 → port 0 gets 32'hFFFF.
- Contention: hold req_valid=11 continuously (writes) for 6 transactions → grants alternate 01,10,01,10,01,10, starting at 01 after reset. Every response is delivered only to its granted port.
- Single requester streaming: port 1 issues 4 back-to-back reads of addrs 0..3 → accepts every 4 cycles, responses in order with the correct data, port 0 never sees rsp_valid.
- Reset mid-operation: assert rst_n=0 during ISSUE of a write to addr 7 with 32'h8031 → ram_we drops at once, no rsp_valid. After reset, reading addr 7 returns its prior value.
- Hold rule: port 1 is kept waiting while port 0 is served and changes nothing until it gets req_ready → port 1's access uses the values it held at its own accept cycle.
